// File: rtl/game_pkg.sv
// Shared encodings for the game control path: difficulty FSM, round timer and
// the BCD digit width used by the display counters.
package game_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        DIFF_SELECT = 2'd0,
        DIFF_PLAY   = 2'd1,
        DIFF_OVER   = 2'd2
    } diff_state_t;

    typedef enum logic [2:0] {
        T_IDLE    = 3'd0,
        T_LOAD    = 3'd1,
        T_RUN     = 3'd2,
        T_SOLVED  = 3'd3,
        T_EXPIRED = 3'd4
    } timer_state_t;

    typedef enum logic [1:0] {
        LVL_NONE   = 2'd0,
        LVL_HARD   = 2'd1,
        LVL_MEDIUM = 2'd2,
        LVL_EASY   = 2'd3
    } level_t;

    // Elaboration-time conversion of a 0..99 budget into {tens, ones}.
    function automatic logic [2*DIGIT_W-1:0] to_bcd(input int s);
        return {DIGIT_W'(s / 10), DIGIT_W'(s % 10)};
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with load, decrement and clear; saturates at 00.
module bcd_down_counter
    import game_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_tens,
    input  logic [DIGIT_W-1:0] load_ones,
    input  logic               dec,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               zero_next
);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            tens <= '0;
            ones <= '0;
        end else if (clear) begin
            tens <= '0;
            ones <= '0;
        end else if (load) begin
            tens <= load_tens;
            ones <= load_ones;
        end else if (dec) begin
            if (ones != '0) begin
                ones <= ones - 1'b1;
            end else if (tens != '0) begin
                ones <= DIGIT_W'(9);
                tens <= tens - 1'b1;
            end
        end
    end

    // High at 01: the next decrement lands on 00.
    assign zero_next = (tens == '0) && (ones == DIGIT_W'(1));

endmodule

// File: rtl/game_timer.sv
// Per-round countdown timer: loads a difficulty budget, counts seconds down in
// BCD and reports win / time-up.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   T_IDLE    | waiting for a play level, digits 00
//   T_LOAD    | one cycle: budget into digits, prescaler cleared
//   T_RUN     | counting down, running = 1
//   T_SOLVED  | maze solved, digits frozen, win = 1
//   T_EXPIRED | budget exhausted, digits 00, timeUp = 1
module game_timer
    import game_pkg::*;
#(
    parameter int CLOCK_HZ       = 50000000,
    parameter int HARD_SECONDS   = 30,
    parameter int MEDIUM_SECONDS = 60,
    parameter int EASY_SECONDS   = 90
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               playHard,
    input  logic               playMedium,
    input  logic               playEasy,
    input  logic               externalReset,
    input  logic               solved,
    output logic [DIGIT_W-1:0] secondsTens,
    output logic [DIGIT_W-1:0] secondsOnes,
    output logic               running,
    output logic               timeUp,
    output logic               win
);

    localparam int PW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
    localparam logic [PW-1:0] TICK_VAL = PW'(CLOCK_HZ - 1);

    localparam logic [2*DIGIT_W-1:0] HARD_BCD   = to_bcd(HARD_SECONDS);
    localparam logic [2*DIGIT_W-1:0] MEDIUM_BCD = to_bcd(MEDIUM_SECONDS);
    localparam logic [2*DIGIT_W-1:0] EASY_BCD   = to_bcd(EASY_SECONDS);

    timer_state_t         state, next_state;
    level_t               level, level_pick;
    logic [PW-1:0]        prescaler;
    logic [2*DIGIT_W-1:0] budget;
    logic                 any_play;
    logic                 tick;
    logic                 cnt_clear, cnt_load, cnt_dec;
    logic                 zero_next;

    assign any_play = playHard | playMedium | playEasy;
    assign tick     = (state == T_RUN) && (prescaler == TICK_VAL);

    always_comb begin
        level_pick = LVL_NONE;
        if (playHard)        level_pick = LVL_HARD;
        else if (playMedium) level_pick = LVL_MEDIUM;
        else if (playEasy)   level_pick = LVL_EASY;
    end

    always_comb begin
        budget = '0;
        case (level)
            LVL_HARD:   budget = HARD_BCD;
            LVL_MEDIUM: budget = MEDIUM_BCD;
            LVL_EASY:   budget = EASY_BCD;
            default:    budget = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= T_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_dec    = 1'b0;
        if (externalReset) begin
            next_state = T_IDLE;
        end else begin
            case (state)
                T_IDLE: begin
                    if (any_play) next_state = T_LOAD;
                end
                T_LOAD: begin
                    next_state = T_RUN;
                end
                T_RUN: begin
                    // solved outranks both abandonment and the tick
                    if (solved) begin
                        next_state = T_SOLVED;
                    end else if (!any_play) begin
                        next_state = T_IDLE;
                    end else if (tick) begin
                        cnt_dec = 1'b1;
                        if (zero_next) next_state = T_EXPIRED;
                    end
                end
                T_SOLVED, T_EXPIRED: begin
                    if (!any_play) next_state = T_IDLE;
                end
                default: begin
                    next_state = T_IDLE;
                end
            endcase
        end
    end

    assign cnt_clear = (next_state == T_IDLE);
    assign cnt_load  = (state == T_LOAD);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            level     <= LVL_NONE;
            prescaler <= '0;
        end else begin
            if (state == T_IDLE && any_play && !externalReset) begin
                level <= level_pick;
            end
            if (state == T_RUN && next_state == T_RUN) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
            end else begin
                prescaler <= '0;
            end
        end
    end

    bcd_down_counter u_digits (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (cnt_clear),
        .load      (cnt_load),
        .load_tens (budget[2*DIGIT_W-1:DIGIT_W]),
        .load_ones (budget[DIGIT_W-1:0]),
        .dec       (cnt_dec),
        .tens      (secondsTens),
        .ones      (secondsOnes),
        .zero_next (zero_next)
    );

    assign running = (state == T_RUN);
    assign timeUp  = (state == T_EXPIRED);
    assign win     = (state == T_SOLVED);

endmodule

// File: tb/tb_game_timer.sv
// Directed-plus-random bench for game_timer; expected outputs come from the
// remaining-seconds arithmetic of each round.
module tb_game_timer;

    localparam int CLK = 4;
    localparam int HS  = 3;
    localparam int MS  = 12;
    localparam int ES  = 20;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       playHard = 1'b0, playMedium = 1'b0, playEasy = 1'b0;
    logic       externalReset = 1'b0, solved = 1'b0;
    logic [3:0] secondsTens, secondsOnes;
    logic       running, timeUp, win;
    logic [10:0] obs;

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int s_cur  = 0;
    int frozen = 0;

    always #5 clock = ~clock;

    game_timer #(
        .CLOCK_HZ       (CLK),
        .HARD_SECONDS   (HS),
        .MEDIUM_SECONDS (MS),
        .EASY_SECONDS   (ES)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .playHard      (playHard),
        .playMedium    (playMedium),
        .playEasy      (playEasy),
        .externalReset (externalReset),
        .solved        (solved),
        .secondsTens   (secondsTens),
        .secondsOnes   (secondsOnes),
        .running       (running),
        .timeUp        (timeUp),
        .win           (win)
    );

    assign obs = {secondsTens, secondsOnes, running, timeUp, win};

    function automatic logic [10:0] pack(input int rem, input bit r, input bit u, input bit w);
        return {4'(rem / 10), 4'(rem % 10), r, u, w};
    endfunction

    // k cycles after RUN entry, a budget of s seconds has s - k/CLK left.
    function automatic logic [10:0] model_run(input int s, input int k);
        int rem;
        rem = s - k / CLK;
        if (rem <= 0) return pack(0, 0, 1, 0);
        return pack(rem, 1, 0, 0);
    endfunction

    task automatic chk(input string tag, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (tens,ones,run,up,win)", tag, obs, exp);
        end
    endtask

    task automatic chk_bcd(input string tag);
        checks++;
        assert ((secondsTens <= 4'd9 && secondsOnes <= 4'd9) === 1'b1) else begin
            errors++;
            $error("FAIL %s_bcd observed=%h%h expected=valid BCD", tag, secondsTens, secondsOnes);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_round(input int s);
        step();
        chk("load", pack(0, 0, 0, 0));
        step();
        n     = 0;
        s_cur = s;
        chk("run_entry", model_run(s, 0));
    endtask

    task automatic advance(input string tag, input int cnt);
        repeat (cnt) begin
            step();
            n++;
            chk(tag, model_run(s_cur, n));
            chk_bcd(tag);
        end
    endtask

    initial begin
        // reset and idle
        step();
        step();
        chk("reset", pack(0, 0, 0, 0));
        resetn = 1'b1;
        repeat (10) begin
            step();
            chk("idle", pack(0, 0, 0, 0));
        end

        // hard countdown to expiry and hold
        playHard = 1'b1;
        start_round(HS);
        advance("hard", HS * CLK);
        advance("hard_hold", 20);
        playHard = 1'b0;
        step();
        chk("hard_release", pack(0, 0, 0, 0));

        // medium: BCD borrow 12..08, then abandon
        playMedium = 1'b1;
        start_round(MS);
        advance("borrow", 4 * CLK + int'($urandom_range(0, 10)));
        playMedium = 1'b0;
        step();
        chk("abandon", pack(0, 0, 0, 0));

        // easy: solve at 17, hold, then externalReset
        playEasy = 1'b1;
        start_round(ES);
        advance("easy", int'($urandom_range(3 * CLK, 4 * CLK - 1)));
        chk("at17", pack(17, 1, 0, 0));
        frozen = ES - n / CLK;
        solved = 1'b1;
        step();
        chk("win", pack(frozen, 0, 0, 1));
        repeat (20) begin
            solved = 1'($urandom_range(0, 1));
            step();
            chk("win_hold", pack(frozen, 0, 0, 1));
        end
        externalReset = 1'b1;
        step();
        chk("ext_reset", pack(0, 0, 0, 0));
        externalReset = 1'b0;
        solved        = 1'b0;
        playEasy      = 1'b0;
        step();
        chk("idle2", pack(0, 0, 0, 0));

        // solved coincident with the tick at 05
        playEasy = 1'b1;
        start_round(ES);
        advance("easy2", (ES - 5) * CLK + CLK - 1);
        solved = 1'b1;
        step();
        chk("solve_on_tick", pack(5, 0, 0, 1));
        solved   = 1'b0;
        playEasy = 1'b0;
        step();
        chk("solved_release", pack(0, 0, 0, 0));

        // externalReset and solved together in RUN
        playMedium = 1'b1;
        start_round(MS);
        advance("med2", int'($urandom_range(0, 20)));
        solved        = 1'b1;
        externalReset = 1'b1;
        step();
        chk("ext_beats_solved", pack(0, 0, 0, 0));
        solved        = 1'b0;
        externalReset = 1'b0;
        playMedium    = 1'b0;
        step();
        chk("idle3", pack(0, 0, 0, 0));

        // resetn mid-round, then a fresh round must start from a clean prescaler
        playEasy = 1'b1;
        start_round(ES);
        advance("easy3", int'($urandom_range(1, 30)));
        resetn = 1'b0;
        step();
        chk("mid_reset", pack(0, 0, 0, 0));
        resetn = 1'b1;
        start_round(ES);
        advance("fresh", 2 * CLK + 1);
        playEasy = 1'b0;
        step();
        chk("idle4", pack(0, 0, 0, 0));

        // hard+easy together picks hard; later level change is ignored
        playHard = 1'b1;
        playEasy = 1'b1;
        start_round(HS);
        advance("prio", 2);
        playHard = 1'b0;
        advance("latched", HS * CLK - 2 + 3);
        playEasy = 1'b0;
        step();
        chk("idle5", pack(0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_timer.md
# game_timer

Per-round countdown timer downstream of the difficulty-selection FSM. It consumes the one-hot play level (playHard/playMedium/playEasy) and the externalReset pulse. It loads a difficulty-specific time budget, counts it down once per second in two BCD digits for the seven-segment display path, and reports round outcome (timeUp or win) back toward the difficulty and input logic.

## Interface

- CLOCK_HZ, 50000000: clock cycles per displayed second; must be ≥ 2.
- HARD_SECONDS, 30: hard budget, range 1..99.
- MEDIUM_SECONDS, 60: medium budget, range 1..99.
- EASY_SECONDS, 90: easy budget, range 1..99.
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- playHard  in  1  hard round active; level, held for the round.
- playMedium  in  1  medium round active.
- playEasy  in  1  easy round active.
- externalReset  in  1  end-of-game pulse from the difficulty FSM.
- solved  in  1  maze exit reached; level, sampled in RUN only.
- secondsTens  out  4  BCD tens digit of time remaining.
- secondsOnes  out  4  BCD ones digit of time remaining.
- running  out  1  high in RUN.
- timeUp  out  1  high in EXPIRED.
- win  out  1  high in SOLVED.

## Operation

- **Reset.** resetn low at an edge forces IDLE. All outputs are 0, the prescaler is 0 and the latched level is cleared.
- **Priority, per edge.** resetn, then externalReset, then state transitions. externalReset high in any state forces IDLE and clears the digits to 00.
- **IDLE.** Outputs 0 and digits 00.
  - If any play input is high, latch the level and go to LOAD.
  - If more than one is high, priority is hard > medium > easy.
- **LOAD (1 cycle).**
  - Digits take the latched budget: tens = S/10, ones = S%10, computed at elaboration.
  - Prescaler clears; next state is RUN.
- **RUN.** running = 1.
  - The prescaler counts 0..CLOCK_HZ-1. A tick is prescaler == CLOCK_HZ-1, after which it wraps to 0.
  - On a tick the digits decrement by one in BCD. If ones == 0, ones becomes 9 and tens decrements.
  - A tick taking the digits from 01 to 00 moves to EXPIRED.
  - solved high moves to SOLVED with the digits unchanged, even on a tick cycle (solved beats the tick).
  - All play inputs low (round abandoned) moves to IDLE with digits cleared to 00.
  - A change of level during RUN is ignored; the latched level governs.
- **SOLVED.** win = 1 and digits are frozen. Leaves to IDLE when all play inputs are low, or on externalReset.
- **EXPIRED.** timeUp = 1 and digits are 00. Leaves to IDLE when all play inputs are low, or on externalReset.
- Digits never underflow below 00 and never hold a non-BCD value.
- The prescaler width is $clog2(CLOCK_HZ). The prescaler only advances in RUN and holds 0 in every other state.

## Timing

- A play input sampled high at edge t (in IDLE) gives LOAD after t.
- RUN and the budget digits are visible after t+1.
- The first decrement is visible after t+1+CLOCK_HZ; each later decrement follows CLOCK_HZ cycles after the previous one.
- Budget S gives EXPIRED, with timeUp = 1, visible S·CLOCK_HZ cycles after RUN entry.
- solved sampled in RUN gives win = 1 and running = 0 on the next cycle.
- All outputs are registered state decodes, with no combinational input-to-output path.
- resetn mid-round takes effect at the next edge; no partial count survives it.

## Structure

- Shared package game_pkg holds:
  - the timer state encoding (IDLE, LOAD, RUN, SOLVED, EXPIRED) as a 3-bit enum/localparam set, next to the difficulty FSM encoding;
  - the BCD digit width constant (4).
- Sub-module bcd_down_counter is natural and is reused by the score display. It is two BCD digits with load (value), decrement enable and clear, and a zero flag for the 01→00 detection.
- The prescaler and the FSM live in game_timer.

## Test plan

Bench uses CLOCK_HZ=4, HARD=3, MEDIUM=12, EASY=20.

- Reset: resetn low 2 cycles → all outputs 0, digits 00; with no play inputs, 10 idle cycles leave all outputs unchanged.
- Hard countdown: playHard held → digits 03 one cycle after LOAD, then 02, 01 at 4-cycle spacing; 00 with timeUp=1 and running=0 12 cycles after RUN entry; still timeUp after 20 more cycles.
- BCD borrow: playMedium held → 12, 11, 10, 09, 08 in sequence; never 0F or other non-BCD value.
- Win and hold: playEasy, assert solved when digits are 17 → win=1 next cycle, digits hold 17 for 20 cycles; an externalReset pulse → IDLE, outputs 0, digits 00 next cycle.
- Simultaneous events: solved coincident with a tick at digits 05 → digits stay 05 and win=1. externalReset and solved in the same RUN cycle → IDLE (externalReset wins).
- Abort paths:
  - all play inputs dropped mid-RUN → IDLE, digits 00 next cycle;
  - resetn low mid-RUN → IDLE;
  - playHard and playEasy both high at start → budget 03 loaded.
